// File: rtl/ram_pkg.sv
// Shared defaults and types for the small bidirectional-bus scratch RAM.
// The top level and storage array take these as parameter defaults.
package ram_pkg;

    localparam int RAM_ADDR_WIDTH = 2;
    localparam int RAM_DATA_WIDTH = 1;
    localparam int DEPTH          = 2 ** RAM_ADDR_WIDTH;

    typedef logic [RAM_ADDR_WIDTH-1:0] addr_t;
    typedef logic [RAM_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/ram_storage_array.sv
// Register array with synchronous clear, one write port and a registered read port.
// Reads and writes are mutually exclusive: the read register only loads when we=0.
module ram_storage_array
    import ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = RAM_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = RAM_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int WORDS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_reg [WORDS];
    logic [DATA_WIDTH-1:0] rd_reg;

    // Every word needs clearing on reset, so the array is built from
    // individually enabled registers rather than a RAM macro.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            logic word_we;
            assign word_we = we && (addr == ADDR_WIDTH'(gi));

            always_ff @(posedge clk) begin
                if (srst) begin
                    mem_reg[gi] <= RESET_VALUE;
                end else if (word_we) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_reg <= RESET_VALUE;
        end else if (!we) begin
            rd_reg <= mem_reg[addr];
        end
    end

    assign rdata = rd_reg;

endmodule

// File: rtl/ram_bidir_sync.sv
// Single-port synchronous RAM on a shared tri-state data line: the master
// drives data while write=1, the RAM drives its read register while write=0.
module ram_bidir_sync
    import ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = RAM_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = RAM_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] rd_q;

    ram_storage_array #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_storage (
        .clk   (clock),
        .srst  (reset),
        .we    (write),
        .addr  (address),
        .wdata (data),
        .rdata (rd_q)
    );

    // Drive enable depends only on write, so address never reaches the bus
    // combinationally; the value driven is always the registered read data.
    assign data = write ? {DATA_WIDTH{1'bz}} : rd_q;

endmodule

// File: tb/tb_ram_bidir_sync.sv
// Directed plus random checks of ram_bidir_sync against an array-based model
// of the reset/write/read rules and the bus ownership rule.
module tb_ram_bidir_sync;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       write = 1'b0;
    logic [1:0] address = 2'd0;
    logic       drv_en = 1'b0;
    logic       drv_val = 1'b0;
    wire        data;

    int errors = 0;
    int checks = 0;

    logic mem_m [4];
    logic rd_m;

    always #5 clock = ~clock;

    assign data = drv_en ? drv_val : 1'bz;

    ram_bidir_sync dut (
        .clock   (clock),
        .reset   (reset),
        .write   (write),
        .address (address),
        .data    (data)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One bus cycle: set inputs at the falling edge, check the combinational
    // drive before the rising edge, apply the rules, check again after it.
    task automatic cyc(input string tag, input logic r, input logic w,
                       input logic [1:0] a, input logic d, input logic do_chk);
        @(negedge clock);
        reset   = r;
        write   = w;
        address = a;
        drv_en  = w;
        drv_val = d;
        #1;
        if (do_chk) check({tag, "/pre"}, data, w ? d : rd_m);
        @(posedge clock);
        if (r) begin
            for (int i = 0; i < 4; i++) mem_m[i] = 1'b0;
            rd_m = 1'b0;
        end else if (w) begin
            mem_m[a] = d;
        end else begin
            rd_m = mem_m[a];
        end
        #1;
        if (do_chk) check({tag, "/post"}, data, w ? d : rd_m);
        $display("cyc %-12s reset=%b write=%b addr=%0d drv=%b data=%b model_rd=%b",
                 tag, r, w, a, d, data, rd_m);
    endtask

    initial begin
        // Reset clear, then read every word.
        cyc("reset", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        check("reset_bus", data, 1'b0);
        for (int i = 0; i < 4; i++) cyc("rd_clear", 1'b0, 1'b0, 2'(i), 1'b0, 1'b1);

        // Single write and read back; other words stay clear.
        cyc("wr2", 1'b0, 1'b1, 2'd2, 1'b1, 1'b1);
        cyc("rd2", 1'b0, 1'b0, 2'd2, 1'b0, 1'b1);
        check("rd2_one", data, 1'b1);
        cyc("rd0", 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        cyc("rd1", 1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
        cyc("rd3", 1'b0, 1'b0, 2'd3, 1'b0, 1'b1);

        // Full pattern 1,0,1,1 then read back in reverse order.
        cyc("pat0", 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
        cyc("pat1", 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
        cyc("pat2", 1'b0, 1'b1, 2'd2, 1'b1, 1'b1);
        cyc("pat3", 1'b0, 1'b1, 2'd3, 1'b1, 1'b1);
        for (int i = 3; i >= 0; i--) cyc("rd_pat", 1'b0, 1'b0, 2'(i), 1'b0, 1'b1);

        // Reset together with a write: the write must be discarded.
        cyc("rst_wr", 1'b1, 1'b1, 2'd1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc("rd_after_rst", 1'b0, 1'b0, 2'(i), 1'b0, 1'b1);

        // Bus release: RAM holds a 1 in rd_q, bench then drives 0 during a write.
        cyc("rel_wr0", 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
        cyc("rel_rd0", 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        cyc("rel_wr1", 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
        cyc("rel_rd1", 1'b0, 1'b0, 2'd1, 1'b0, 1'b1);

        // Back-to-back write then read of the same address.
        cyc("b2b_wr3", 1'b0, 1'b1, 2'd3, 1'b1, 1'b1);
        cyc("b2b_wr3", 1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
        cyc("b2b_rd3", 1'b0, 1'b0, 2'd3, 1'b0, 1'b1);
        check("b2b_zero", data, 1'b0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 300; n++) begin
            cyc("rand", ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
